// File: rtl/exmem_mmio_if.sv
// exmem_mmio_if: datapath-side bus of the exmem_mmio memory block.
//
// Signals:
//   en          data-port enable; when low the data port does nothing and
//               memdata holds its value.
//   memwrite    write strobe, sampled on the rising clock edge when en=1.
//   memread     read strobe; the word appears on memdata after that edge.
//   link        when set with en=1, memdata returns pc+1 instead of a read.
//   pc          instruction fetch address.
//   adr         data address (RAM or the 16-word MMIO window).
//   writedata   write data.
//   memdata     registered data read result.
//   instruction registered instruction fetch result.
//
// Transfer semantics: there is no valid/ready back-pressure. Every strobe
// qualified by en is accepted on the edge where it is sampled, and read
// results are valid exactly one cycle later.
interface exmem_mmio_if #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10,
    parameter int PC_BITS       = 9
);
    logic                     en;
    logic                     memwrite;
    logic                     memread;
    logic                     link;
    logic [PC_BITS-1:0]       pc;
    logic [RAM_ADDR_BITS-1:0] adr;
    logic [WIDTH-1:0]         writedata;
    logic [WIDTH-1:0]         memdata;
    logic [WIDTH-1:0]         instruction;

    modport master (
        output en, memwrite, memread, link, pc, adr, writedata,
        input  memdata, instruction
    );

    modport slave (
        input  en, memwrite, memread, link, pc, adr, writedata,
        output memdata, instruction
    );
endinterface

// File: rtl/exmem_mmio.sv
// exmem_mmio: unified instruction/data RAM with a 16-word memory-mapped I/O
// window holding game control/status registers, synchronised inputs, sticky
// event flags, an LFSR and player score registers with atomic commit.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   bus            exmem_mmio_if slave: en/memwrite/memread/link/pc/adr/
//                  writedata in, memdata/instruction out
//   player_input   async player event input (rising edge sets FLAGS bit0)
//   all_buttons    async any-button level (rising edge sets FLAGS bit1)
//   first_player   first-responder id, registered every cycle
//   switch_input   async switches, 2-flop synchronised
//   random_val     writedata captured by the last commit
//   players        committed player scores, player i at [i*WIDTH +: WIDTH]
//   winner_num, screen_status, game_status   live control registers
//   commit_pulse   high for the single cycle after a commit write
module exmem_mmio #(
    parameter int          WIDTH         = 16,
    parameter int          RAM_ADDR_BITS = 10,
    parameter int          PC_BITS       = 9,
    parameter int          NUM_PLAYERS   = 4,
    parameter int          MMIO_BASE     = 528,
    parameter int          SW_BITS       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    exmem_mmio_if.slave                  bus,
    input  logic                         player_input,
    input  logic                         all_buttons,
    input  logic [1:0]                   first_player,
    input  logic [SW_BITS-1:0]           switch_input,
    output logic [WIDTH-1:0]             random_val,
    output logic [NUM_PLAYERS*WIDTH-1:0] players,
    output logic [2:0]                   winner_num,
    output logic [1:0]                   screen_status,
    output logic [2:0]                   game_status,
    output logic                         commit_pulse
);
    localparam int DEPTH    = 1 << RAM_ADDR_BITS;
    localparam int WIN_LAST = MMIO_BASE + 15;
    // A window that does not fit in the RAM address space is disabled and
    // those addresses behave as ordinary RAM.
    localparam bit WIN_OK   = (WIN_LAST < DEPTH);

    logic [WIDTH-1:0] ram [DEPTH];

    logic                     in_win, pc_in_win;
    logic [3:0]               off;
    logic [RAM_ADDR_BITS-1:0] pc_idx;
    logic [PC_BITS-1:0]       pc_inc;
    logic                     wr_ram, wr_win, commit;

    logic [WIDTH-1:0]             memdata_q, instr_q;
    logic [2:0]                   game_q, winner_q;
    logic [1:0]                   screen_q, fp_q;
    logic [1:0]                   flags_q, flags_d, flag_set, flag_clr;
    logic [2:0]                   pi_sync_q, ab_sync_q;
    logic [SW_BITS-1:0]           sw_s1_q, sw_s2_q;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic [7:0]                   cnt_q;
    logic [WIDTH-1:0]             player_q [NUM_PLAYERS];
    logic [NUM_PLAYERS*WIDTH-1:0] players_q, players_d;
    logic [WIDTH-1:0]             random_q;
    logic                         pulse_q;
    logic [WIDTH-1:0]             pl_rdata, win_rdata;

    assign in_win    = WIN_OK && (int'(bus.adr) >= MMIO_BASE) && (int'(bus.adr) <= WIN_LAST);
    assign pc_in_win = WIN_OK && (int'(bus.pc) >= MMIO_BASE) && (int'(bus.pc) <= WIN_LAST);
    // MMIO_BASE is 16-aligned, so adr - MMIO_BASE inside the window is adr[3:0].
    assign off       = bus.adr[3:0];
    assign pc_idx    = RAM_ADDR_BITS'(bus.pc);
    assign pc_inc    = bus.pc + PC_BITS'(1);
    assign wr_ram    = bus.en & bus.memwrite & ~in_win;
    assign wr_win    = bus.en & bus.memwrite & in_win;
    assign commit    = wr_win & (off == 4'd7);

    // Sticky flags: a rise on the synchronised signal sets, W1C clears, set wins.
    assign flag_set = {ab_sync_q[1] & ~ab_sync_q[2], pi_sync_q[1] & ~pi_sync_q[2]};
    assign flag_clr = (wr_win && off == 4'd4) ? bus.writedata[1:0] : 2'b00;
    assign flags_d  = (flags_q & ~flag_clr) | flag_set;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (lfsr_q == 16'h0) lfsr_d = LFSR_SEED;
    end

    always_comb begin
        players_d = '0;
        pl_rdata  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            players_d[i*WIDTH +: WIDTH] = player_q[i];
            if (off[3] && off[2:0] == 3'(i)) pl_rdata = player_q[i];
        end
    end

    always_comb begin
        win_rdata = '0;
        case (off)
            4'd0:    win_rdata = WIDTH'(game_q);
            4'd1:    win_rdata = WIDTH'(screen_q);
            4'd2:    win_rdata = WIDTH'(winner_q);
            4'd3:    win_rdata = WIDTH'(fp_q);
            4'd4:    win_rdata = WIDTH'(flags_q);
            4'd5:    win_rdata = WIDTH'(sw_s2_q);
            4'd6:    win_rdata = WIDTH'(lfsr_q);
            4'd7:    win_rdata = WIDTH'(cnt_q);
            default: win_rdata = pl_rdata;
        endcase
    end

    // RAM array has no reset; window addresses never write it.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[bus.adr] <= bus.writedata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memdata_q <= '0;
            instr_q   <= '0;
            game_q    <= '0;
            screen_q  <= '0;
            winner_q  <= '0;
            fp_q      <= '0;
            flags_q   <= '0;
            pi_sync_q <= '0;
            ab_sync_q <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= '0;
            players_q <= '0;
            random_q  <= '0;
            pulse_q   <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) player_q[i] <= '0;
        end else begin
            instr_q   <= pc_in_win ? '0 : ram[pc_idx];
            fp_q      <= first_player;
            pi_sync_q <= {pi_sync_q[1:0], player_input};
            ab_sync_q <= {ab_sync_q[1:0], all_buttons};
            sw_s1_q   <= switch_input;
            sw_s2_q   <= sw_s1_q;
            lfsr_q    <= lfsr_d;
            flags_q   <= flags_d;
            pulse_q   <= commit;

            if (bus.en) begin
                if (bus.link)         memdata_q <= WIDTH'(pc_inc);
                else if (bus.memread) memdata_q <= in_win ? win_rdata : ram[bus.adr];
            end

            if (wr_win) begin
                case (off)
                    4'd0:    game_q   <= bus.writedata[2:0];
                    4'd1:    screen_q <= bus.writedata[1:0];
                    4'd2:    winner_q <= bus.writedata[2:0];
                    default: ;
                endcase
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (off[3] && off[2:0] == 3'(i)) player_q[i] <= bus.writedata;
                end
            end

            // Snapshot uses the player registers as they were before this edge.
            if (commit) begin
                players_q <= players_d;
                random_q  <= bus.writedata;
                cnt_q     <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.memdata     = memdata_q;
    assign bus.instruction = instr_q;
    assign random_val      = random_q;
    assign players         = players_q;
    assign winner_num      = winner_q;
    assign screen_status   = screen_q;
    assign game_status     = game_q;
    assign commit_pulse    = pulse_q;
endmodule

// File: tb/tb_exmem_mmio.sv
module tb_exmem_mmio;
    localparam int          BASE = 528;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk, rst;
    logic        player_input, all_buttons;
    logic [1:0]  first_player;
    logic [7:0]  switch_input;
    logic [15:0] random_val;
    logic [63:0] players;
    logic [2:0]  winner_num;
    logic [1:0]  screen_status;
    logic [2:0]  game_status;
    logic        commit_pulse;

    exmem_mmio_if #(.WIDTH(16), .RAM_ADDR_BITS(10), .PC_BITS(9)) bus ();

    exmem_mmio #(
        .WIDTH(16), .RAM_ADDR_BITS(10), .PC_BITS(9), .NUM_PLAYERS(4),
        .MMIO_BASE(BASE), .SW_BITS(8), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .player_input(player_input), .all_buttons(all_buttons),
        .first_player(first_player), .switch_input(switch_input),
        .random_val(random_val), .players(players), .winner_num(winner_num),
        .screen_status(screen_status), .game_status(game_status),
        .commit_pulse(commit_pulse)
    );

    int          tests, fails;
    logic [15:0] exp_q[$];
    logic [15:0] got, exp;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b0; bus.memwrite = 1'b0; bus.memread = 1'b0; bus.link = 1'b0;
    endtask

    function automatic logic [9:0] win(input int o);
        return 10'(BASE + o);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s == 16'h0) return SEED;
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        bus.en = 1'b1; bus.memwrite = 1'b1; bus.adr = a; bus.writedata = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [9:0] a, input logic [15:0] e);
        bus.en = 1'b1; bus.memread = 1'b1; bus.adr = a;
        exp_q.push_back(e);
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({bus.memdata, bus.instruction} !== 32'h0) begin
            $display("FAIL reset_bus: got %h required 0", {bus.memdata, bus.instruction}); fails++;
        end
        tests++;
        if ({winner_num, screen_status, game_status, commit_pulse} !== 9'h0) begin
            $display("FAIL reset_ctrl: got %h required 0", {winner_num, screen_status, game_status, commit_pulse}); fails++;
        end
        tests++;
        if ({players, random_val} !== 80'h0) begin
            $display("FAIL reset_players: got %h required 0", {players, random_val}); fails++;
        end
        rst = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [15:0] r1, r2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rd(win(6), lfsr_next(SEED));
        got = bus.memdata; exp = exp_q.pop_front(); r1 = got; tests++;
        if (got !== exp) begin $display("FAIL lfsr_first: got %h required %h", got, exp); fails++; end
        rd(win(6), lfsr_next(lfsr_next(SEED)));
        got = bus.memdata; exp = exp_q.pop_front(); r2 = got; tests++;
        if (got !== exp) begin $display("FAIL lfsr_second: got %h required %h", got, exp); fails++; end
        tests++;
        if (r1 === r2 || r1 === 16'h0 || r2 === 16'h0) begin
            $display("FAIL lfsr_distinct: got %h,%h required distinct nonzero", r1, r2); fails++;
        end
    endtask

    task automatic test_ram();
        wr(10'd5, 16'h1234);
        bus.pc = 9'd5;
        rd(10'd5, 16'h1234);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL ram_read: got %h required %h", got, exp); fails++; end
        tests++;
        if (bus.instruction !== 16'h1234) begin
            $display("FAIL ifetch: got %h required 1234", bus.instruction); fails++;
        end
        bus.en = 1'b1; bus.memwrite = 1'b1; bus.memread = 1'b1; bus.adr = 10'd5; bus.writedata = 16'hBEEF;
        exp_q.push_back(16'h1234);
        tick();
        idle();
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL rbw_old: got %h required %h", got, exp); fails++; end
        rd(10'd5, 16'hBEEF);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL rbw_new: got %h required %h", got, exp); fails++; end
    endtask

    task automatic test_link();
        bus.pc = 9'h1FF; bus.en = 1'b1; bus.link = 1'b1; bus.memread = 1'b1; bus.adr = 10'd5;
        exp_q.push_back(16'h0000);
        tick();
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL link_wrap: got %h required %h", got, exp); fails++; end
        bus.pc = 9'h010;
        exp_q.push_back(16'h0011);
        tick();
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL link_inc: got %h required %h", got, exp); fails++; end
        idle();
        bus.memread = 1'b1; bus.adr = 10'd5;
        exp_q.push_back(16'h0011);
        tick();
        idle();
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL en_hold: got %h required %h", got, exp); fails++; end
    endtask

    task automatic test_window();
        wr(win(0), 16'h0007);
        tests++;
        if (game_status !== 3'b111) begin $display("FAIL game_out: got %b required 111", game_status); fails++; end
        rd(win(0), 16'h0007);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL game_rd: got %h required %h", got, exp); fails++; end
        wr(win(1), 16'hFFFF);
        tests++;
        if (screen_status !== 2'b11) begin $display("FAIL screen_out: got %b required 11", screen_status); fails++; end
        rd(win(1), 16'h0003);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL screen_rd: got %h required %h", got, exp); fails++; end
        wr(win(2), 16'h0005);
        tests++;
        if (winner_num !== 3'd5) begin $display("FAIL winner_out: got %0d required 5", winner_num); fails++; end
        first_player = 2'd2;
        tick();
        rd(win(3), 16'h0002);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL first_player: got %h required %h", got, exp); fails++; end
        switch_input = 8'hA5;
        tick(); tick();
        rd(win(5), 16'h00A5);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL switches: got %h required %h", got, exp); fails++; end
        wr(win(12), 16'd99);
        rd(win(12), 16'h0000);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL player_oor: got %h required %h", got, exp); fails++; end
    endtask

    task automatic test_flags();
        player_input = 1'b1; tick(); player_input = 1'b0;
        tick(); tick();
        rd(win(4), 16'h0001);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL flag_set_k3: got %h required %h", got, exp); fails++; end
        wr(win(4), 16'h0001);
        rd(win(4), 16'h0000);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL flag_w1c: got %h required %h", got, exp); fails++; end
        // set the flag, then W1C on the very edge a second rise lands
        player_input = 1'b1; tick(); player_input = 1'b0;
        repeat (4) tick();
        player_input = 1'b1; tick(); player_input = 1'b0;
        tick();
        wr(win(4), 16'h0001);
        rd(win(4), 16'h0001);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL flag_set_wins: got %h required %h", got, exp); fails++; end
        wr(win(4), 16'h0001);
        all_buttons = 1'b1;
        tick(); tick(); tick();
        rd(win(4), 16'h0002);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL btn_flag: got %h required %h", got, exp); fails++; end
        wr(win(4), 16'h0002);
        rd(win(4), 16'h0000);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL btn_level_no_reset: got %h required %h", got, exp); fails++; end
        all_buttons = 1'b0;
    endtask

    task automatic test_commit();
        int npulse;
        wr(win(8), 16'd10); wr(win(9), 16'd20); wr(win(10), 16'd30); wr(win(11), 16'd40);
        tests++;
        if (players !== 64'h0) begin $display("FAIL players_precommit: got %h required 0", players); fails++; end
        wr(win(7), 16'h00FF);
        tests++;
        if (commit_pulse !== 1'b1) begin $display("FAIL commit_pulse: got %b required 1", commit_pulse); fails++; end
        tests++;
        if (players !== 64'h0028_001E_0014_000A) begin
            $display("FAIL players_commit: got %h required 0028001e0014000a", players); fails++;
        end
        tests++;
        if (random_val !== 16'h00FF) begin $display("FAIL random_val: got %h required 00ff", random_val); fails++; end
        wr(win(8), 16'd11);
        tests++;
        if (commit_pulse !== 1'b0 || players[15:0] !== 16'h000A) begin
            $display("FAIL pulse_single_snapshot: got %b/%h required 0/000a", commit_pulse, players[15:0]); fails++;
        end
        rd(win(7), 16'h0001);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL commit_count1: got %h required %h", got, exp); fails++; end
        npulse = 0;
        bus.en = 1'b1; bus.memwrite = 1'b1; bus.adr = win(7); bus.writedata = 16'h0055;
        repeat (255) begin
            tick();
            if (commit_pulse === 1'b1) npulse++;
        end
        idle();
        tests++;
        if (npulse !== 255) begin $display("FAIL b2b_pulses: got %0d required 255", npulse); fails++; end
        tests++;
        if (players[15:0] !== 16'h000B) begin $display("FAIL players_recommit: got %h required 000b", players[15:0]); fails++; end
        rd(win(7), 16'h0000);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL commit_wrap: got %h required %h", got, exp); fails++; end
        tests++;
        if (commit_pulse !== 1'b0) begin $display("FAIL pulse_idle: got %b required 0", commit_pulse); fails++; end
    endtask

    task automatic test_reset_mid();
        bus.en = 1'b1; bus.memwrite = 1'b1; bus.adr = win(7); bus.writedata = 16'h1234;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({winner_num, screen_status, game_status, commit_pulse} !== 9'h0) begin
            $display("FAIL async_ctrl: got %h required 0", {winner_num, screen_status, game_status, commit_pulse}); fails++;
        end
        tests++;
        if ({players, random_val, bus.memdata, bus.instruction} !== 112'h0) begin
            $display("FAIL async_data: got %h required 0", {players, random_val, bus.memdata, bus.instruction}); fails++;
        end
        tick();
        idle();
        tests++;
        if (commit_pulse !== 1'b0 || random_val !== 16'h0) begin
            $display("FAIL reset_beats_commit: got %b/%h required 0/0000", commit_pulse, random_val); fails++;
        end
        rst = 1'b0;
        rd(10'd5, 16'hBEEF);
        got = bus.memdata; exp = exp_q.pop_front(); tests++;
        if (got !== exp) begin $display("FAIL ram_survives_reset: got %h required %h", got, exp); fails++; end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        player_input = 1'b0; all_buttons = 1'b0; first_player = 2'd0; switch_input = 8'h00;
        idle();
        bus.pc = '0; bus.adr = '0; bus.writedata = '0;
        test_reset();
        test_lfsr();
        test_ram();
        test_link();
        test_window();
        test_flags();
        test_commit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exmem_mmio.md
Name: exmem_mmio

Overview:
- Parametrised successor to the unified instruction/data memory: single-port synchronous RAM, separate instruction-fetch read port, 16-word memory-mapped I/O window.
- MMIO window holds game status/control registers, synchronised switch and button inputs, sticky W1C event flags, a free-running LFSR, and NUM_PLAYERS score registers.
- A commit write snapshots the player registers to the display outputs atomically.
- Sits between the datapath (pc, adr, writedata) and the game/VGA logic.

Parameters:
- WIDTH, 16, data word width.
- RAM_ADDR_BITS, 10, RAM address width; depth 2**RAM_ADDR_BITS.
- PC_BITS, 9, width of pc.
- NUM_PLAYERS, 4, implemented player registers, legal range 1..8.
- MMIO_BASE, 528, first address of the 16-word window; multiple of 16.
- SW_BITS, 8, switch input width, at most WIDTH.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  data-port enable.
- memwrite  in  1  data write strobe.
- memread  in  1  data read strobe.
- link  in  1  return pc+1 on memdata.
- pc  in  PC_BITS  instruction fetch address.
- adr  in  RAM_ADDR_BITS  data address.
- writedata  in  WIDTH  write data.
- player_input  in  1  async player-input event.
- all_buttons  in  1  async any-button level.
- first_player  in  2  first-responder id.
- switch_input  in  SW_BITS  async switches.
- memdata  out  WIDTH  data read result.
- instruction  out  WIDTH  fetched word.
- random_val  out  WIDTH  value latched at commit.
- players  out  NUM_PLAYERS*WIDTH  committed scores; player i at [i*WIDTH +: WIDTH].
- winner_num  out  3  winner register.
- screen_status  out  2  screen register.
- game_status  out  3  game register.
- commit_pulse  out  1  one-cycle pulse after commit.

Behaviour:
- Reset: async on rst. All outputs and registers go to 0, commit counter goes to 0, synchronisers clear, LFSR loads LFSR_SEED. RAM contents are not reset.
- Latency:
  - Data reads: 1 cycle.
  - instruction <= ram[pc] every edge. pc inside the window fetches 0.
- Data port (acts only when en=1):
  - Write to RAM: read-before-write. memread to the same address returns the old word.
  - Window address (MMIO_BASE..MMIO_BASE+15): never touches RAM. Decode uses offset = adr-MMIO_BASE.
  - link has priority over memread: memdata <= zero-extended pc+1, wrapping at 2**PC_BITS.
  - en=0: memdata holds its value.
- Window offsets, all zero-extended:
  - 0 GAME_STATUS, RW [2:0].
  - 1 SCREEN_STATUS, RW [1:0].
  - 2 WINNER, RW [2:0].
  - 3 FIRST_PLAYER, RO, registered each cycle.
  - 4 FLAGS, RO/W1C. bit0 = sticky player-input rise, bit1 = sticky all_buttons rise. Same-cycle set and W1C: set wins.
  - 5 SWITCHES, RO, 2-flop synchronised.
  - 6 RANDOM, RO, current LFSR state.
  - 7 COMMIT. Read returns 8-bit commit count, wrapping 255->0. Any write commits.
  - 8..15 PLAYER[0..7], RW. Offsets at or above 8+NUM_PLAYERS read 0 and ignore writes.
- Synchronisers and edge detect:
  - player_input and all_buttons pass through 2 flops each; a rising edge on a synchronised signal sets its flag.
  - Timing: if the input goes high before edge k, the flag reads 1 via a read issued at edge k+3, returned after that edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
  - State 0 reloads LFSR_SEED.
  - RANDOM returns the low WIDTH bits, zero-extended if WIDTH>16.
- Commit (en & memwrite & offset 7) at edge k:
  - players <= PLAYER regs as they were before edge k.
  - random_val <= writedata.
  - Commit count increments.
  - commit_pulse=1 for exactly the cycle after edge k.
  - Back-to-back commits give consecutive pulses.
- Reset mid-commit: reset wins; no pulse, outputs stay 0.
- Out-of-range adr: the window must lie inside the RAM address space, otherwise the address is ordinary RAM.

Test Plan:
- Reset, then ram[5]=16'h1234 via write, then memread adr 5 -> memdata=16'h1234 one cycle later. Same-cycle write 16'hBEEF and read -> 16'h1234 first, 16'hBEEF on next read.
- link=1, memread=1, pc=9'h1FF -> memdata=0 (wrap). Window write offset 0 value 7 -> game_status=3'b111 and ram[MMIO_BASE] unchanged.
- Pulse player_input high 1 cycle -> FLAGS read returns 1 by edge k+3. W1C 16'h1 clears it. W1C coincident with a new rise -> flag stays 1.
- Write PLAYER0..3 = 10,20,30,40, commit with writedata 16'h00FF -> players={40,30,20,10}, random_val=16'h00FF, single commit_pulse, COMMIT read=1. 256 commits -> count=0.
- Reset, read RANDOM twice back-to-back -> distinct nonzero values; first equals one shift beyond LFSR_SEED per elapsed cycle.
- Assert rst mid-sequence -> all outputs 0 asynchronously; RAM word written earlier still reads back after reset release.
